mem_port_arbiter: RTL

//  Shares the single-ported byte-banked data memory (10-bit addr, combinational read,

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, byte-banked data memory (combinational read,
// posedge write) between the instruction-fetch stage and the MEM stage.
// At most one requester owns the memory port per cycle. The owner's read data
// is captured at the end of the grant cycle and presented on *_rdata together
// with a one-cycle *_rvalid pulse in the following cycle. A streak counter
// bounds how many data grants in a row may win while a fetch is waiting.
//
// Optional feature macro: MEM_ARB_PERF_CNT_EN
//   When defined, adds two saturating 16-bit performance counters
//   (perf_if_stall, perf_conflict). When undefined, those ports do not exist
//   and timing is identical.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and byte address (always a word read)
//   if_gnt              fetch owns the memory this cycle (combinational)
//   if_rvalid/if_rdata  registered fetch data, valid for one cycle
//   d_req/d_we/d_addr   data request, store flag, byte address
//   d_wdata/d_u/d_type  store data, unsigned-load flag, access size
//                       (00 word, 01 half, 10 byte, 11 illegal)
//   d_gnt               data side owns the memory this cycle (combinational)
//   d_rvalid/d_rdata    registered load data, valid for one cycle
//   d_err               registered pulse: illegal d_type on a granted access
//   mem_*               memory port (we, addr, wdata, u, type, rdata)
//   perf_if_stall       cycles with if_req=1 and if_gnt=0  (macro only)
//   perf_conflict       cycles with if_req=1 and d_req=1   (macro only)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned AW           = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic          d_u,
  input  logic [1:0]    d_type,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_u,
  output logic [1:0]    mem_type,
  input  logic [31:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [15:0]   perf_if_stall,
  output logic [15:0]   perf_conflict
`endif
);

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'b00,
    OWN_DATA  = 2'b01,
    OWN_FETCH = 2'b10
  } owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  // Access size 11 is not a legal memory access.
  function automatic logic type_illegal(input logic [1:0] t);
    return (t == 2'b11);
  endfunction

  owner_t     grant_s;
  owner_t     owner_r;
  logic [3:0] streak_r;
  logic [3:0] streak_nxt_s;
  logic       d_illegal_s;
  logic       d_load_ok_s;

  // Combinational grant; a held reset forces IDLE so nothing is written.
  always_comb begin
    grant_s = OWN_IDLE;
    if (!rst) begin
      grant_s = OWN_IDLE;
    end else begin
      case ({d_req, if_req})
        2'b11:   grant_s = (streak_r == STREAK_MAX) ? OWN_FETCH : OWN_DATA;
        2'b10:   grant_s = OWN_DATA;
        2'b01:   grant_s = OWN_FETCH;
        default: grant_s = OWN_IDLE;
      endcase
    end
  end

  assign if_gnt = (grant_s == OWN_FETCH);
  assign d_gnt  = (grant_s == OWN_DATA);

  assign d_illegal_s = d_gnt & type_illegal(d_type);
  assign d_load_ok_s = d_gnt & ~d_we & ~type_illegal(d_type);

  // Streak only counts data wins that actually made a fetch wait.
  always_comb begin
    streak_nxt_s = streak_r;
    if (!if_req || (grant_s == OWN_FETCH)) begin
      streak_nxt_s = 4'd0;
    end else if ((grant_s == OWN_DATA) && (streak_r != STREAK_MAX)) begin
      streak_nxt_s = streak_r + 4'd1;
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  // Memory port mux driven by the current owner.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = 32'h0000_0000;
    mem_u     = 1'b0;
    mem_type  = 2'b00;
    case (grant_s)
      OWN_FETCH: begin
        mem_addr = if_addr;
      end
      OWN_DATA: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_u     = d_u;
        mem_type  = d_type;
        mem_we    = d_we & ~type_illegal(d_type);
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Owner FSM plus the registered return path captured at the grant cycle's end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r  <= OWN_IDLE;
      streak_r <= 4'd0;
      if_rdata <= 32'h0000_0000;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'h0000_0000;
      d_err    <= 1'b0;
    end else begin
      owner_r  <= grant_s;
      streak_r <= streak_nxt_s;
      d_rvalid <= d_load_ok_s;
      d_err    <= d_illegal_s;
      if (grant_s == OWN_FETCH) begin
        if_rdata <= mem_rdata;
      end else begin
        if_rdata <= if_rdata;
      end
      // An illegal access returns zero instead of whatever the memory drove.
      if (d_illegal_s) begin
        d_rdata <= 32'h0000_0000;
      end else if (d_load_ok_s) begin
        d_rdata <= mem_rdata;
      end else begin
        d_rdata <= d_rdata;
      end
    end
  end

  // Fetch data is valid exactly in the cycle after a fetch grant.
  assign if_rvalid = (owner_r == OWN_FETCH);

`ifdef MEM_ARB_PERF_CNT_EN
  // Saturating stall/conflict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_stall <= 16'h0000;
      perf_conflict <= 16'h0000;
    end else begin
      if (if_req && !if_gnt && (perf_if_stall != 16'hFFFF)) begin
        perf_if_stall <= perf_if_stall + 16'h0001;
      end else begin
        perf_if_stall <= perf_if_stall;
      end
      if (if_req && d_req && (perf_conflict != 16'hFFFF)) begin
        perf_conflict <= perf_conflict + 16'h0001;
      end else begin
        perf_conflict <= perf_conflict;
      end
    end
  end
`endif

endmodule
